// File: rtl/iobus_timer.sv
// Memory-mapped IOBUS timer: prescaled 32-bit counter with compare match,
// optional auto-reload and a level interrupt. Read data and SEL are registered.
module iobus_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        SEL,
    output logic        INT
);

    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_COUNT   = 2'd1;
    localparam logic [1:0] IDX_COMPARE = 2'd2;
    localparam logic [1:0] IDX_STATUS  = 2'd3;

    logic                  en_r;
    logic                  ar_r;
    logic                  ie_r;
    logic [PRESCALE_W-1:0] ps_r;
    logic [PRESCALE_W-1:0] ps_cnt_r;
    logic [31:0]           count_r;
    logic [31:0]           compare_r;
    logic                  pend_r;
    logic [31:0]           rd_data_r;
    logic                  sel_r;

    logic        hit_s;
    logic [1:0]  idx_s;
    logic        wr_ctrl_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        tick_s;
    logic        match_s;
    logic [31:0] ctrl_word_s;
    logic [31:0] rd_next_s;

    // Address decode and per-register write strobes.
    always_comb begin
        hit_s        = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (IOBUS_ADDR[1:0] == 2'b00);
        idx_s        = IOBUS_ADDR[3:2];
        wr_ctrl_s    = 1'b0;
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_status_s  = 1'b0;
        if (IOBUS_WR && hit_s) begin
            case (idx_s)
                IDX_CTRL:    wr_ctrl_s    = 1'b1;
                IDX_COUNT:   wr_count_s   = 1'b1;
                IDX_COMPARE: wr_compare_s = 1'b1;
                IDX_STATUS:  wr_status_s  = 1'b1;
                default:     wr_ctrl_s    = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // A CTRL write restarts the prescaler, so it never ticks in that cycle;
    // a COUNT write discards the tick entirely, including any match.
    always_comb begin
        tick_s  = en_r && (ps_cnt_r == ps_r) && !wr_ctrl_s;
        match_s = tick_s && !wr_count_s && (count_r == compare_r);
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        ctrl_word_s                   = 32'd0;
        ctrl_word_s[0]                = en_r;
        ctrl_word_s[1]                = ar_r;
        ctrl_word_s[2]                = ie_r;
        ctrl_word_s[8 +: PRESCALE_W]  = ps_r;
        rd_next_s                     = 32'd0;
        if (hit_s) begin
            case (idx_s)
                IDX_CTRL:    rd_next_s = ctrl_word_s;
                IDX_COUNT:   rd_next_s = count_r;
                IDX_COMPARE: rd_next_s = compare_r;
                IDX_STATUS:  rd_next_s = {31'd0, pend_r};
                default:     rd_next_s = 32'd0;
            endcase
        end else begin
            rd_next_s = 32'd0;
        end
    end

    // CTRL register and prescale counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            en_r     <= 1'b0;
            ar_r     <= 1'b0;
            ie_r     <= 1'b0;
            ps_r     <= {PRESCALE_W{1'b0}};
            ps_cnt_r <= {PRESCALE_W{1'b0}};
        end else begin
            if (wr_ctrl_s) begin
                en_r <= IOBUS_OUT[0];
                ar_r <= IOBUS_OUT[1];
                ie_r <= IOBUS_OUT[2];
                ps_r <= IOBUS_OUT[8 +: PRESCALE_W];
            end
            if (wr_ctrl_s || !en_r || (ps_cnt_r == ps_r)) begin
                ps_cnt_r <= {PRESCALE_W{1'b0}};
            end else begin
                ps_cnt_r <= ps_cnt_r + PRESCALE_W'(1);
            end
        end
    end

    // COUNT, COMPARE and PEND; a match-set beats a simultaneous STATUS clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            pend_r    <= 1'b0;
        end else begin
            if (wr_compare_s) begin
                compare_r <= IOBUS_OUT;
            end
            if (wr_count_s) begin
                count_r <= IOBUS_OUT;
            end else if (match_s && ar_r) begin
                count_r <= 32'd0;
            end else if (tick_s) begin
                count_r <= count_r + 32'd1;
            end
            if (match_s) begin
                pend_r <= 1'b1;
            end else if (wr_status_s && IOBUS_OUT[0]) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Registered bus read response.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_data_r <= 32'd0;
            sel_r     <= 1'b0;
        end else begin
            rd_data_r <= rd_next_s;
            sel_r     <= hit_s;
        end
    end

    assign RD_DATA = rd_data_r;
    assign SEL     = sel_r;
    assign INT     = pend_r & ie_r;

endmodule

// File: tb/tb_iobus_timer.sv
// Directed bench for iobus_timer: register-access vector table plus
// hand-written prescale, wrap, collision and mid-count reset sequences.
module tb_iobus_timer;

    localparam logic [31:0] A_CTRL  = 32'h1100_0100;
    localparam logic [31:0] A_COUNT = 32'h1100_0104;
    localparam logic [31:0] A_CMP   = 32'h1100_0108;
    localparam logic [31:0] A_STAT  = 32'h1100_010C;

    logic        CLK;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        SEL;
    logic        INT;

    int checks;
    int failures;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_sel;
        logic        exp_int;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    iobus_timer #(
        .BASE_ADDR  (32'h1100_0100),
        .PRESCALE_W (8)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .RD_DATA    (RD_DATA),
        .SEL        (SEL),
        .INT        (INT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        IOBUS_WR   = wr;
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
        IOBUS_OUT  = 32'd0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RST_N      = 1'b0;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = A_CMP;
        IOBUS_OUT  = 32'd0;

        vecs[0]  = '{1'b0, A_CMP,          32'd0,          32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, A_CTRL,         32'd0,          32'd0,         1'b1, 1'b0};
        vecs[2]  = '{1'b0, A_COUNT,        32'd0,          32'd0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, A_STAT,         32'd0,          32'd0,         1'b1, 1'b0};
        vecs[4]  = '{1'b1, A_COUNT,        32'h1234_5678,  32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b0, A_COUNT,        32'd0,          32'h1234_5678, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h1100_0110,  32'd0,          32'd0,         1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h1100_0105,  32'd0,          32'd0,         1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h1100_0106,  32'd0,          32'd0,         1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h1100_0114,  32'd0,          32'd0,         1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h1110_0104,  32'd0,          32'd0,         1'b0, 1'b0};
        vecs[11] = '{1'b0, A_COUNT,        32'd0,          32'h1234_5678, 1'b1, 1'b0};
        vecs[12] = '{1'b1, A_CTRL,         32'hFFFF_FFFE,  32'd0,         1'b1, 1'b0};
        vecs[13] = '{1'b0, A_CTRL,         32'd0,          32'h0000_FF06, 1'b1, 1'b0};
        vecs[14] = '{1'b1, A_CTRL,         32'd0,          32'h0000_FF06, 1'b1, 1'b0};
        vecs[15] = '{1'b0, A_CTRL,         32'd0,          32'd0,         1'b1, 1'b0};

        // Reset held for two edges while a hit address is presented.
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("reset_rd",  RD_DATA,       32'd0);
        check("reset_sel", {31'd0, SEL},  32'd0);
        check("reset_int", {31'd0, INT},  32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].wr, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_rd", i),  RD_DATA,      vecs[i].exp_rd);
            check($sformatf("vec%0d_sel", i), {31'd0, SEL}, {31'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_int", i), {31'd0, INT}, {31'd0, vecs[i].exp_int});
        end

        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, A_COUNT, 32'd0);
            check("hold_count", RD_DATA, 32'h1234_5678);
        end

        // Prescale 2 with auto-reload and interrupt: ticks 3 cycles apart.
        cyc(1'b1, A_COUNT, 32'd0);
        cyc(1'b1, A_CMP, 32'd3);
        cyc(1'b1, A_CTRL, 32'h0000_0207);
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b0, A_COUNT, 32'd0);
            check($sformatf("ps_count_%0d", k), RD_DATA, 32'((k - 1) / 3));
            check($sformatf("ps_int_%0d", k), {31'd0, INT}, {31'd0, (k == 12)});
        end
        cyc(1'b0, A_COUNT, 32'd0);
        check("ar_reload", RD_DATA, 32'd0);
        check("ar_int_hi", {31'd0, INT}, 32'd1);
        cyc(1'b1, A_STAT, 32'd0);
        check("stat_pend", RD_DATA, 32'd1);
        check("stat_w0_int", {31'd0, INT}, 32'd1);
        cyc(1'b1, A_STAT, 32'd1);
        check("stat_w1_int", {31'd0, INT}, 32'd0);
        cyc(1'b0, A_STAT, 32'd0);
        check("stat_clear", RD_DATA, 32'd0);
        cyc(1'b1, A_CTRL, 32'd0);

        // No-reload wrap with PS=0 and IE=0.
        cyc(1'b1, A_COUNT, 32'hFFFF_FFFE);
        cyc(1'b1, A_CMP, 32'd5);
        cyc(1'b1, A_CTRL, 32'h0000_0001);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, A_COUNT, 32'd0);
            check($sformatf("wrap_count_%0d", k), RD_DATA, 32'hFFFF_FFFE + 32'(k - 1));
            check($sformatf("wrap_int_%0d", k), {31'd0, INT}, 32'd0);
        end
        cyc(1'b0, A_STAT, 32'd0);
        check("wrap_pend", RD_DATA, 32'd1);
        check("wrap_int", {31'd0, INT}, 32'd0);

        // COUNT write on a tick cycle: written value wins.
        cyc(1'b1, A_COUNT, 32'd100);
        cyc(1'b0, A_COUNT, 32'd0);
        check("coll_count", RD_DATA, 32'd100);
        cyc(1'b0, A_COUNT, 32'd0);
        check("coll_count_next", RD_DATA, 32'd101);

        // STATUS clear on the match cycle: set wins.
        cyc(1'b1, A_CTRL, 32'd0);
        cyc(1'b1, A_STAT, 32'd1);
        cyc(1'b1, A_COUNT, 32'd10);
        cyc(1'b1, A_CMP, 32'd10);
        cyc(1'b1, A_CTRL, 32'h0000_0001);
        cyc(1'b1, A_STAT, 32'd1);
        check("coll_pend_old", RD_DATA, 32'd0);
        cyc(1'b0, A_STAT, 32'd0);
        check("coll_pend_set", RD_DATA, 32'd1);

        // Reset while counting with PEND=1 and IE=1.
        cyc(1'b1, A_CTRL, 32'h0000_0005);
        check("pre_rst_int", {31'd0, INT}, 32'd1);
        RST_N      = 1'b0;
        IOBUS_ADDR = A_COUNT;
        @(posedge CLK);
        #1;
        check("mid_rst_rd",  RD_DATA,      32'd0);
        check("mid_rst_sel", {31'd0, SEL}, 32'd0);
        check("mid_rst_int", {31'd0, INT}, 32'd0);
        RST_N = 1'b1;
        cyc(1'b0, A_CTRL, 32'd0);
        check("post_rst_ctrl", RD_DATA, 32'd0);
        cyc(1'b0, A_COUNT, 32'd0);
        check("post_rst_count", RD_DATA, 32'd0);
        cyc(1'b0, A_STAT, 32'd0);
        check("post_rst_pend", RD_DATA, 32'd0);
        cyc(1'b0, A_CMP, 32'd0);
        check("post_rst_cmp", RD_DATA, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
